match_ctrl: RTL and testbench

Parametrised match controller for the pong core. It sits between the ball engine and the player inputs, and runs the freeze/serve/play/game-over sequence. It keeps per-player scores up to a configurable winning score and ramps ball speed during a rally. Serve direction alternates toward the player who last conceded. Everything is clocked by the 1 kHz game tick, so one cycle is 1 ms.

---
 rtl/match_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_match_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/match_ctrl.sv
// Match controller for the pong core. It sequences freeze, serve, play
// and game-over, keeps both scores and ramps the ball speed during a rally.
// One game_clk cycle is one millisecond.
module match_ctrl #(
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int FREEZE_W     = 14,
    parameter int START_FREEZE = 16383,
    parameter int POINT_FREEZE = 2000,
    parameter int SPEED_W      = 5,
    parameter int SERVE_SPEED  = 11,
    parameter int MAX_SPEED    = 15,
    parameter int RAMP_MS      = 1000
) (
    input  logic                      game_clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      out_left,
    input  logic                      out_right,
    output logic signed [SPEED_W-1:0] speed,
    output logic                      ball_reset,
    output logic [SCORE_W-1:0]        score_l,
    output logic [SCORE_W-1:0]        score_r,
    output logic                      game_over,
    output logic                      winner,
    output logic [1:0]                state
);

    typedef enum logic [1:0] {
        ST_FREEZE = 2'b00,
        ST_PLAY   = 2'b01,
        ST_OVER   = 2'b10
    } state_t;

    // Ramp counter only needs to hold 0 .. RAMP_MS-1.
    localparam int RAMP_W = (RAMP_MS > 1) ? $clog2(RAMP_MS) : 1;

    localparam logic [RAMP_W-1:0]          RAMP_LAST   = RAMP_W'((RAMP_MS > 0) ? RAMP_MS - 1 : 0);
    localparam logic [RAMP_W-1:0]          RAMP_ONE    = RAMP_W'(1);
    localparam logic [FREEZE_W-1:0]        FREEZE_ONE  = FREEZE_W'(1);
    localparam logic [FREEZE_W-1:0]        FREEZE_INIT = FREEZE_W'(START_FREEZE);
    localparam logic [FREEZE_W-1:0]        FREEZE_PT   = FREEZE_W'(POINT_FREEZE);
    localparam logic [SCORE_W-1:0]         SCORE_ONE   = SCORE_W'(1);
    localparam logic [SCORE_W-1:0]         SCORE_WIN   = SCORE_W'(WIN_SCORE);
    localparam logic signed [SPEED_W-1:0]  SPEED_ONE   = SPEED_W'(1);
    localparam logic signed [SPEED_W-1:0]  SERVE_POS   = SPEED_W'(SERVE_SPEED);
    localparam logic signed [SPEED_W-1:0]  SERVE_NEG   = SPEED_W'(-SERVE_SPEED);
    localparam logic signed [SPEED_W-1:0]  MAX_POS     = SPEED_W'(MAX_SPEED);
    localparam logic signed [SPEED_W-1:0]  MAX_NEG     = SPEED_W'(-MAX_SPEED);

    state_t                      r_state,      w_state_next;
    logic [FREEZE_W-1:0]         r_freeze,     w_freeze_next;
    logic [RAMP_W-1:0]           r_ramp,       w_ramp_next;
    logic signed [SPEED_W-1:0]   r_speed,      w_speed_next;
    logic                        r_ball_reset, w_ball_reset_next;
    logic [SCORE_W-1:0]          r_score_l,    w_score_l_next;
    logic [SCORE_W-1:0]          r_score_r,    w_score_r_next;
    logic                        r_game_over,  w_game_over_next;
    logic                        r_winner,     w_winner_next;
    logic                        r_serve_dir,  w_serve_dir_next;
    logic                        r_start_q,    w_start_q_next;

    logic [SCORE_W-1:0]          w_score_l_inc;
    logic [SCORE_W-1:0]          w_score_r_inc;

    assign w_score_l_inc = r_score_l + SCORE_ONE;
    assign w_score_r_inc = r_score_r + SCORE_ONE;

    // State and datapath registers; reset wins over every input.
    always_ff @(posedge game_clk) begin
        if (reset) begin
            r_state      <= ST_FREEZE;
            r_freeze     <= FREEZE_INIT;
            r_ramp       <= '0;
            r_speed      <= '0;
            r_ball_reset <= 1'b1;
            r_score_l    <= '0;
            r_score_r    <= '0;
            r_game_over  <= 1'b0;
            r_winner     <= 1'b0;
            r_serve_dir  <= 1'b0;
            r_start_q    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_freeze     <= w_freeze_next;
            r_ramp       <= w_ramp_next;
            r_speed      <= w_speed_next;
            r_ball_reset <= w_ball_reset_next;
            r_score_l    <= w_score_l_next;
            r_score_r    <= w_score_r_next;
            r_game_over  <= w_game_over_next;
            r_winner     <= w_winner_next;
            r_serve_dir  <= w_serve_dir_next;
            r_start_q    <= w_start_q_next;
        end
    end

    // Next-state logic: freeze countdown, serve, scoring, speed ramp, rematch.
    always_comb begin
        w_state_next      = r_state;
        w_freeze_next     = r_freeze;
        w_ramp_next       = r_ramp;
        w_speed_next      = r_speed;
        w_score_l_next    = r_score_l;
        w_score_r_next    = r_score_r;
        w_game_over_next  = r_game_over;
        w_winner_next     = r_winner;
        w_serve_dir_next  = r_serve_dir;
        w_start_q_next    = start;
        // Pulse lands in the cycle where freeze has just reached zero.
        w_ball_reset_next = (r_state == ST_FREEZE) && (r_freeze == FREEZE_ONE);

        case (r_state)
            ST_FREEZE: begin
                if (r_freeze != '0) begin
                    // Start shortens the wait but the final 1->0 step always happens.
                    w_freeze_next = (start && (r_freeze > FREEZE_ONE)) ? FREEZE_ONE
                                                                       : r_freeze - FREEZE_ONE;
                end else begin
                    w_state_next = ST_PLAY;
                    w_speed_next = r_serve_dir ? SERVE_NEG : SERVE_POS;
                    w_ramp_next  = '0;
                end
            end
            ST_PLAY: begin
                if (out_left) begin
                    w_score_r_next   = w_score_r_inc;
                    w_serve_dir_next = 1'b1;
                    w_speed_next     = '0;
                    if (w_score_r_inc == SCORE_WIN) begin
                        w_state_next     = ST_OVER;
                        w_game_over_next = 1'b1;
                        w_winner_next    = 1'b1;
                    end else begin
                        w_state_next  = ST_FREEZE;
                        w_freeze_next = FREEZE_PT;
                    end
                end else if (out_right) begin
                    w_score_l_next   = w_score_l_inc;
                    w_serve_dir_next = 1'b0;
                    w_speed_next     = '0;
                    if (w_score_l_inc == SCORE_WIN) begin
                        w_state_next     = ST_OVER;
                        w_game_over_next = 1'b1;
                        w_winner_next    = 1'b0;
                    end else begin
                        w_state_next  = ST_FREEZE;
                        w_freeze_next = FREEZE_PT;
                    end
                end else if (RAMP_MS != 0) begin
                    if (r_ramp == RAMP_LAST) begin
                        w_ramp_next = '0;
                        // Grow magnitude away from zero, keeping the sign.
                        if (r_speed[SPEED_W-1]) begin
                            if (r_speed > MAX_NEG) w_speed_next = r_speed - SPEED_ONE;
                        end else begin
                            if (r_speed < MAX_POS) w_speed_next = r_speed + SPEED_ONE;
                        end
                    end else begin
                        w_ramp_next = r_ramp + RAMP_ONE;
                    end
                end
            end
            ST_OVER: begin
                // Rematch on a fresh press; serve_dir is left alone so the loser serves.
                if (start && !r_start_q) begin
                    w_score_l_next   = '0;
                    w_score_r_next   = '0;
                    w_game_over_next = 1'b0;
                    w_state_next     = ST_FREEZE;
                    w_freeze_next    = FREEZE_PT;
                end
            end
            default: begin
                w_state_next = ST_FREEZE;
            end
        endcase
    end

    assign speed      = r_speed;
    assign ball_reset = r_ball_reset;
    assign score_l    = r_score_l;
    assign score_r    = r_score_r;
    assign game_over  = r_game_over;
    assign winner     = r_winner;
    assign state      = r_state;

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: directed walk through the match sequence followed by
// random play, all checked every cycle against a behavioural match model.
module tb_match_ctrl;

    localparam int SCORE_W      = 4;
    localparam int WIN_SCORE    = 3;
    localparam int FREEZE_W     = 14;
    localparam int START_FREEZE = 20;
    localparam int POINT_FREEZE = 5;
    localparam int SPEED_W      = 5;
    localparam int SERVE_SPEED  = 11;
    localparam int MAX_SPEED    = 13;
    localparam int RAMP_MS      = 3;

    logic                      game_clk;
    logic                      reset;
    logic                      start;
    logic                      out_left;
    logic                      out_right;
    logic signed [SPEED_W-1:0] speed;
    logic                      ball_reset;
    logic [SCORE_W-1:0]        score_l;
    logic [SCORE_W-1:0]        score_r;
    logic                      game_over;
    logic                      winner;
    logic [1:0]                state;

    int n_total = 0;
    int n_bad   = 0;

    // Match model: phase 0 freeze, 1 play, 2 over.
    int m_phase, m_freeze, m_sl, m_sr, m_over, m_win, m_serve, m_dir, m_rally, m_br, m_sq;

    match_ctrl #(
        .SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE), .FREEZE_W(FREEZE_W),
        .START_FREEZE(START_FREEZE), .POINT_FREEZE(POINT_FREEZE),
        .SPEED_W(SPEED_W), .SERVE_SPEED(SERVE_SPEED), .MAX_SPEED(MAX_SPEED),
        .RAMP_MS(RAMP_MS)
    ) dut (
        .game_clk(game_clk), .reset(reset), .start(start),
        .out_left(out_left), .out_right(out_right),
        .speed(speed), .ball_reset(ball_reset), .score_l(score_l), .score_r(score_r),
        .game_over(game_over), .winner(winner), .state(state)
    );

    initial game_clk = 1'b0;
    always #5 game_clk = ~game_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Speed the model expects: serve magnitude plus one per full RAMP_MS of rally.
    function automatic int model_speed();
        int mag;
        if (m_phase != 1) return 0;
        mag = SERVE_SPEED + m_rally / RAMP_MS;
        if (mag > MAX_SPEED) mag = MAX_SPEED;
        return m_dir ? -mag : mag;
    endfunction

    task automatic model_point(input int to_right);
        if (to_right) begin m_sr++; m_serve = 1; end
        else          begin m_sl++; m_serve = 0; end
        if ((to_right ? m_sr : m_sl) == WIN_SCORE) begin
            m_phase = 2; m_over = 1; m_win = to_right;
        end else begin
            m_phase = 0; m_freeze = POINT_FREEZE;
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit l, input bit rt);
        if (r) begin
            m_phase = 0; m_freeze = START_FREEZE; m_sl = 0; m_sr = 0; m_over = 0;
            m_win = 0; m_serve = 0; m_dir = 0; m_rally = 0; m_br = 1; m_sq = 0;
            return;
        end
        m_br = (m_phase == 0 && m_freeze == 1) ? 1 : 0;
        case (m_phase)
            0: begin
                if (m_freeze != 0) m_freeze = (s && m_freeze > 1) ? 1 : m_freeze - 1;
                else begin m_phase = 1; m_rally = 0; m_dir = m_serve; end
            end
            1: begin
                if (l)       model_point(1);
                else if (rt) model_point(0);
                else         m_rally++;
            end
            default: begin
                if (s && !m_sq) begin
                    m_sl = 0; m_sr = 0; m_over = 0; m_phase = 0; m_freeze = POINT_FREEZE;
                end
            end
        endcase
        m_sq = s;
    endtask

    // One clock: drive inputs, model the edge, then compare on the falling edge.
    task automatic cyc(input bit r, input bit s, input bit l, input bit rt);
        reset = r; start = s; out_left = l; out_right = rt;
        @(posedge game_clk);
        model_step(r, s, l, rt);
        @(negedge game_clk);
        chk("state",      int'(state),       m_phase);
        chk("speed",      int'(speed),       model_speed());
        chk("ball_reset", int'(ball_reset),  m_br);
        chk("score_l",    int'(score_l),     m_sl);
        chk("score_r",    int'(score_r),     m_sr);
        chk("game_over",  int'(game_over),   m_over);
        chk("winner",     int'(winner),      m_win);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    initial begin
        bit st_lvl;
        // Reset and unassisted start freeze.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_ball_reset", int'(ball_reset), 1);
        chk("rst_speed", int'(speed), 0);
        idle(19);
        chk("br_not_early", int'(ball_reset), 0);
        idle(1);
        chk("br_pulse", int'(ball_reset), 1);
        idle(1);
        chk("first_serve", int'(speed), 11);
        chk("first_play", int'(state), 1);

        // Right-side out: left scores, serve stays toward the right.
        idle(2);
        cyc(0, 0, 0, 1);
        chk("pt_score_l", int'(score_l), 1);
        chk("pt_stop", int'(speed), 0);
        chk("pt_freeze", int'(state), 0);
        idle(5);
        chk("pt_br", int'(ball_reset), 1);
        idle(1);
        chk("pt_serve", int'(speed), 11);

        // Simultaneous outs: left-out wins, next serve toward the left.
        cyc(0, 0, 1, 1);
        chk("both_r", int'(score_r), 1);
        chk("both_l", int'(score_l), 1);
        idle(6);
        chk("both_serve", int'(speed), -11);

        // Ramp and saturation.
        idle(3);
        chk("ramp1", int'(speed), -12);
        idle(3);
        chk("ramp2", int'(speed), -13);
        idle(3);
        chk("ramp_sat", int'(speed), -13);

        // Win with start held across entry to OVER.
        cyc(0, 0, 1, 0);
        idle(6);
        cyc(0, 1, 1, 0);
        chk("win_over", int'(game_over), 1);
        chk("win_who", int'(winner), 1);
        chk("win_state", int'(state), 2);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 1);
        chk("over_hold", int'(state), 2);
        chk("over_ign", int'(score_l), 1);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("rematch_state", int'(state), 0);
        chk("rematch_sr", int'(score_r), 0);
        idle(6);
        chk("rematch_serve", int'(speed), -11);

        // Start held from reset: freeze jumps to 1.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("hold_br", int'(ball_reset), 1);
        cyc(0, 1, 0, 0);
        chk("hold_serve", int'(speed), 11);

        // Random play.
        st_lvl = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) st_lvl = ~st_lvl;
            cyc(($urandom_range(499) == 0),
                st_lvl,
                ($urandom_range(11) == 0),
                ($urandom_range(11) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
